// File: rtl/load_wr_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_wr_buffer_if                                            |
// | Description : Loader-side, RAM-side and CPU-jump signals of load_wr_buffer |
// |               (checksum present only with LOAD_WR_CHECKSUM_EN).            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface load_wr_buffer_if #(
  parameter int DATA = 8,
  parameter int ADDR = 16
);
  logic            in_download;
  logic            in_wr;
  logic [ADDR-1:0] in_addr;
  logic [DATA-1:0] in_data;
  logic            in_exec;
  logic [ADDR-1:0] in_exec_addr;
  logic            hold;
  logic            mem_req;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_data;
  logic            mem_ack;
  logic            jump;
  logic [ADDR-1:0] jump_addr;
  logic            busy;
  logic            overflow;
`ifdef LOAD_WR_CHECKSUM_EN
  logic [DATA-1:0] checksum;
`endif

  modport master (
    output in_download, in_wr, in_addr, in_data, in_exec, in_exec_addr, mem_ack,
    input  hold, mem_req, mem_addr, mem_data, jump, jump_addr, busy, overflow
`ifdef LOAD_WR_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  in_download, in_wr, in_addr, in_data, in_exec, in_exec_addr, mem_ack,
    output hold, mem_req, mem_addr, mem_data, jump, jump_addr, busy, overflow
`ifdef LOAD_WR_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface
`default_nettype wire

// File: rtl/load_wr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_wr_buffer                                               |
// | Description : Buffers loader byte writes in a FIFO, drains them to RAM and |
// |               fires the CPU jump once earlier writes are acked.            |
// |               Optional checksum output: define LOAD_WR_CHECKSUM_EN.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module load_wr_buffer #(
  parameter int DATA  = 8,
  parameter int ADDR  = 16,
  parameter int DEPTH = 8
) (
  input wire              clock,
  input wire              reset,
  load_wr_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_HOLD = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    JUMP = 2'd3
  } state_t;

  state_t               r_state;
  logic [ADDR+DATA-1:0] r_fifo [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_mem_req;
  logic [ADDR-1:0]      r_mem_addr;
  logic [DATA-1:0]      r_mem_data;
  logic                 r_jump;
  logic [ADDR-1:0]      r_jump_addr;
  logic                 r_pending;
  logic                 r_overflow;
  logic                 r_download_q;

  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_dl_rise;
  logic [ADDR+DATA-1:0] w_head;

  assign w_empty   = (r_count == '0);
  assign w_push    = bus.in_wr && (r_count != C_FULL);
  assign w_drop    = bus.in_wr && (r_count == C_FULL);
  // The head stays queued until acked, so count includes the in-flight write
  assign w_pop     = (r_state == REQ) && bus.mem_ack;
  assign w_dl_rise = bus.in_download && !r_download_q;
  assign w_head    = r_fifo[r_rptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {bus.in_addr, bus.in_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_jump       <= 1'b0;
      r_jump_addr  <= '0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
      r_download_q <= 1'b0;
    end else begin
      r_download_q <= bus.in_download;

      if (w_drop)         r_overflow <= 1'b1;
      else if (w_dl_rise) r_overflow <= 1'b0;

      // A fresh execute request wins over a same-cycle clear
      if (bus.in_exec) begin
        r_jump_addr <= bus.in_exec_addr;
        r_pending   <= 1'b1;
      end else if (w_dl_rise || (r_state == JUMP)) begin
        r_pending   <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_head[ADDR+DATA-1:DATA];
            r_mem_data <= w_head[DATA-1:0];
          end else if (r_pending) begin
            r_state <= JUMP;
            r_jump  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            r_state   <= GAP;
            r_mem_req <= 1'b0;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        JUMP: begin
          r_state <= IDLE;
          r_jump  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_jump    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOAD_WR_CHECKSUM_EN
  logic [DATA-1:0] r_checksum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_dl_rise) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + r_mem_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

  assign bus.hold      = (r_count >= C_HOLD);
  assign bus.busy      = !w_empty || (r_state != IDLE) || r_pending;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.jump      = r_jump;
  assign bus.jump_addr = r_jump_addr;
  assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_load_wr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_wr_buffer                                            |
// | Description : Directed self-checking bench for load_wr_buffer.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_load_wr_buffer;
  localparam int DATA  = 8;
  localparam int ADDR  = 16;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   auto_ack = 1'b0;

  int          wr_cnt     = 0;
  int          req_rise   = 0;
  int          jump_cnt   = 0;
  int          wr_at_jump = 0;
  logic        req_q      = 1'b0;
  logic [15:0] log_addr [64];
  logic [7:0]  log_data [64];

  load_wr_buffer_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

  load_wr_buffer #(.DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM-side observer: records accepted writes, request rises and jump pulses
  always @(posedge clock) begin
    if (bus.mem_req && bus.mem_ack) begin
      if (wr_cnt < 64) begin
        log_addr[wr_cnt] = bus.mem_addr;
        log_data[wr_cnt] = bus.mem_data;
      end
      wr_cnt++;
    end
    if (bus.mem_req && !req_q) req_rise++;
    req_q = bus.mem_req;
    if (bus.jump) begin
      jump_cnt++;
      wr_at_jump = wr_cnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clock);
    #1;
    if (auto_ack) bus.mem_ack = bus.mem_req && !bus.mem_ack;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    bus.in_wr   = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    cycle();
    bus.in_wr   = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!bus.busy) break;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b, required 0 within 100 cycles", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    cycle();
    cycle();
    n_checks++; if (bus.mem_req !== 1'b0)    begin n_fail++; $display("FAIL rst_mem_req: got %b, expected 0", bus.mem_req); end
    n_checks++; if (bus.jump !== 1'b0)       begin n_fail++; $display("FAIL rst_jump: got %b, expected 0", bus.jump); end
    n_checks++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_overflow: got %b, expected 0", bus.overflow); end
    n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    n_checks++; if (bus.hold !== 1'b0)       begin n_fail++; $display("FAIL rst_hold: got %b, expected 0", bus.hold); end
    n_checks++; if (bus.mem_addr !== 16'h0)  begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0000", bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 8'h0)   begin n_fail++; $display("FAIL rst_mem_data: got %h, expected 00", bus.mem_data); end
    n_checks++; if (bus.jump_addr !== 16'h0) begin n_fail++; $display("FAIL rst_jump_addr: got %h, expected 0000", bus.jump_addr); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_latency();
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    push(16'h1234, 8'hAB);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1_req: got %b, expected 0", bus.mem_req); end
    n_checks++; if (bus.busy !== 1'b1)    begin n_fail++; $display("FAIL lat_cycle1_busy: got %b, expected 1", bus.busy); end
    cycle();
    n_checks++; if (bus.mem_req !== 1'b1)      begin n_fail++; $display("FAIL lat_cycle2_req: got %b, expected 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL lat_addr: got %h, expected 1234", bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 8'hAB)    begin n_fail++; $display("FAIL lat_data: got %h, expected ab", bus.mem_data); end
    cycle();
    cycle();
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h1234) begin
      n_fail++; $display("FAIL req_stable: got req=%b addr=%h, expected req=1 addr=1234", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    cycle();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL gap_req: got %b, expected 0", bus.mem_req); end
    cycle();
    cycle();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lat_idle_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_ack_ignored();
    bus.mem_ack = 1'b1;
    cycle();
    cycle();
    bus.mem_ack = 1'b0;
    cycle();
    n_checks++; if (dut.r_count !== 4'd0) begin n_fail++; $display("FAIL stray_ack_count: got %0d, expected 0", dut.r_count); end
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack_state: got busy=%b req=%b, expected 0 0", bus.busy, bus.mem_req);
    end
  endtask

  task automatic test_two_writes();
    int base  = wr_cnt;
    int rbase = req_rise;
    auto_ack = 1'b1;
    push(16'h4000, 8'h11);
    push(16'h4001, 8'h22);
    drain("two_writes");
    auto_ack = 1'b0;
    n_checks++; if (wr_cnt - base != 2) begin n_fail++; $display("FAIL two_wr_count: got %0d, expected 2", wr_cnt - base); end
    n_checks++; if (log_addr[base] !== 16'h4000 || log_data[base] !== 8'h11) begin
      n_fail++; $display("FAIL two_wr_first: got %h/%h, expected 4000/11", log_addr[base], log_data[base]);
    end
    n_checks++; if (log_addr[base+1] !== 16'h4001 || log_data[base+1] !== 8'h22) begin
      n_fail++; $display("FAIL two_wr_second: got %h/%h, expected 4001/22", log_addr[base+1], log_data[base+1]);
    end
    n_checks++; if (req_rise - rbase != 2) begin n_fail++; $display("FAIL two_wr_req_gap: got %0d request rises, expected 2", req_rise - rbase); end
  endtask

  task automatic test_overflow();
    int   base = wr_cnt;
    logic exp_hold;
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(16'(16'h4100 + i), 8'(8'h30 + i));
      exp_hold = (i >= 5);
      n_checks++; if (bus.hold !== exp_hold) begin n_fail++; $display("FAIL hold_push%0d: got %b, expected %b", i + 1, bus.hold, exp_hold); end
    end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop: got %b, expected 0", bus.overflow); end
    push(16'h41FF, 8'hEE);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drop: got %b, expected 1", bus.overflow); end
    n_checks++; if (dut.r_count !== 4'd8)  begin n_fail++; $display("FAIL ovf_count: got %0d, expected 8", dut.r_count); end
    auto_ack = 1'b1;
    drain("overflow");
    auto_ack = 1'b0;
    n_checks++; if (wr_cnt - base != 8) begin n_fail++; $display("FAIL ovf_wr_count: got %0d, expected 8", wr_cnt - base); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (log_addr[base+i] !== 16'(16'h4100 + i) || log_data[base+i] !== 8'(8'h30 + i)) begin
        n_fail++; $display("FAIL ovf_wr%0d: got %h/%h, expected %h/%h", i, log_addr[base+i], log_data[base+i], 16'(16'h4100 + i), 8'(8'h30 + i));
      end
    end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", bus.overflow); end
    bus.in_download = 1'b1;
    cycle();
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_dl_clear: got %b, expected 0", bus.overflow); end
    bus.in_download = 1'b0;
    cycle();
  endtask

  task automatic test_push_pop();
    int base = wr_cnt;
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    push(16'h6000, 8'hA0);
    push(16'h6001, 8'hA1);
    push(16'h6002, 8'hA2);
    n_checks++; if (dut.r_count !== 4'd3 || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL pp_setup: got count=%0d req=%b, expected 3 1", dut.r_count, bus.mem_req);
    end
    bus.mem_ack = 1'b1;
    push(16'h6003, 8'hA3);
    bus.mem_ack = 1'b0;
    n_checks++; if (dut.r_count !== 4'd3) begin n_fail++; $display("FAIL pp_count: got %0d, expected 3", dut.r_count); end
    auto_ack = 1'b1;
    drain("push_pop");
    auto_ack = 1'b0;
    n_checks++; if (wr_cnt - base != 4) begin n_fail++; $display("FAIL pp_wr_count: got %0d, expected 4", wr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (log_addr[base+i] !== 16'(16'h6000 + i) || log_data[base+i] !== 8'(8'hA0 + i)) begin
        n_fail++; $display("FAIL pp_wr%0d: got %h/%h, expected %h/%h", i, log_addr[base+i], log_data[base+i], 16'(16'h6000 + i), 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_jump();
    int base  = wr_cnt;
    int jbase = jump_cnt;
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    push(16'h5000, 8'h01);
    push(16'h5001, 8'h02);
    push(16'h5002, 8'h03);
    bus.in_exec      = 1'b1;
    bus.in_exec_addr = 16'h5100;
    cycle();
    bus.in_exec_addr = 16'h5200;
    cycle();
    bus.in_exec = 1'b0;
    n_checks++; if (bus.jump_addr !== 16'h5200) begin n_fail++; $display("FAIL jmp_addr_latch: got %h, expected 5200", bus.jump_addr); end
    n_checks++; if (bus.jump !== 1'b0)          begin n_fail++; $display("FAIL jmp_early: got %b, expected 0", bus.jump); end
    auto_ack = 1'b1;
    drain("jump");
    auto_ack = 1'b0;
    n_checks++; if (jump_cnt - jbase != 1)   begin n_fail++; $display("FAIL jmp_pulses: got %0d, expected 1", jump_cnt - jbase); end
    n_checks++; if (wr_at_jump != base + 3)  begin n_fail++; $display("FAIL jmp_order: got %0d writes before jump, expected 3", wr_at_jump - base); end
    n_checks++; if (bus.jump_addr !== 16'h5200) begin n_fail++; $display("FAIL jmp_addr_hold: got %h, expected 5200", bus.jump_addr); end
  endtask

  task automatic test_download();
    int base  = wr_cnt;
    int jbase = jump_cnt;
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    push(16'h7000, 8'h55);
    bus.in_exec      = 1'b1;
    bus.in_exec_addr = 16'h7100;
    cycle();
    bus.in_exec     = 1'b0;
    bus.in_download = 1'b1;
    cycle();
    push(16'h7001, 8'h66);
    bus.in_download = 1'b0;
    cycle();
    auto_ack = 1'b1;
    drain("download");
    auto_ack = 1'b0;
    n_checks++; if (jump_cnt - jbase != 0) begin n_fail++; $display("FAIL dl_pending_clear: got %0d jumps, expected 0", jump_cnt - jbase); end
    n_checks++; if (wr_cnt - base != 2)    begin n_fail++; $display("FAIL dl_fifo_kept: got %0d writes, expected 2", wr_cnt - base); end
    n_checks++; if (log_addr[base] !== 16'h7000 || log_addr[base+1] !== 16'h7001) begin
      n_fail++; $display("FAIL dl_order: got %h,%h, expected 7000,7001", log_addr[base], log_addr[base+1]);
    end
  endtask

  task automatic test_reset_mid_req();
    int jbase = jump_cnt;
    auto_ack    = 1'b0;
    bus.mem_ack = 1'b0;
    push(16'h5300, 8'h77);
    bus.in_exec      = 1'b1;
    bus.in_exec_addr = 16'h5300;
    cycle();
    bus.in_exec = 1'b0;
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_setup_req: got %b, expected 1", bus.mem_req); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b, expected 0", bus.mem_req); end
    n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_busy: got %b, expected 0", bus.busy); end
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    cycle();
    n_checks++; if (jump_cnt != jbase) begin n_fail++; $display("FAIL mid_rst_jump: got %0d jumps, expected 0", jump_cnt - jbase); end
    n_checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_after: got req=%b busy=%b, expected 0 0", bus.mem_req, bus.busy);
    end
  endtask

`ifdef LOAD_WR_CHECKSUM_EN
  task automatic test_checksum();
    n_checks++; if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL cks_reset: got %h, expected 00", bus.checksum); end
    auto_ack = 1'b1;
    push(16'h8000, 8'hF0);
    push(16'h8001, 8'h20);
    push(16'h8002, 8'h01);
    drain("checksum");
    auto_ack = 1'b0;
    n_checks++; if (bus.checksum !== 8'h11) begin n_fail++; $display("FAIL cks_sum: got %h, expected 11", bus.checksum); end
    bus.in_download = 1'b1;
    cycle();
    bus.in_download = 1'b0;
    n_checks++; if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL cks_dl_clear: got %h, expected 00", bus.checksum); end
  endtask
`endif

  initial begin
    bus.in_download  = 1'b0;
    bus.in_wr        = 1'b0;
    bus.in_addr      = '0;
    bus.in_data      = '0;
    bus.in_exec      = 1'b0;
    bus.in_exec_addr = '0;
    bus.mem_ack      = 1'b0;
    test_reset();
    test_latency();
    test_ack_ignored();
    test_two_writes();
    test_overflow();
    test_push_pop();
    test_jump();
    test_download();
    test_reset_mid_req();
`ifdef LOAD_WR_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
